extencion_signo: RTL and testbench



---
 rtl/extencion_signo.sv | 87 ++++++++
 tb/tb_extencion_signo.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/extencion_signo.sv
// Immediate-extension unit. Produces the sign, zero, branch-offset and
// upper-immediate forms of the instruction immediate combinationally. A
// registered copy of one of them is loaded under ext_en, chosen by ext_mode.
//
// Load protocol: ext_en is a one-cycle load strobe with no backpressure.
// Every rising clk edge with ext_en=1 captures a new value. oext_valid
// rises with the first load and stays high until the next reset. It tells
// consumers that oext_q no longer holds the reset value.
module extencion_signo #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  instr,
  output logic [OUT_W-1:0] oinstr,
  output logic [OUT_W-1:0] ozext,
  output logic [OUT_W-1:0] obranch,
  output logic [OUT_W-1:0] olui,
  input  logic [1:0]       ext_mode,
  input  logic             ext_en,
  output logic [OUT_W-1:0] oext_q,
  output logic             oext_valid
);

  localparam int PAD_W = OUT_W - IN_W;

  typedef enum logic [1:0] {
    MODE_SIGN   = 2'b00,
    MODE_ZERO   = 2'b01,
    MODE_BRANCH = 2'b10,
    MODE_LUI    = 2'b11
  } ext_mode_e;

  logic [OUT_W-1:0] sel_ext;
  logic [OUT_W-1:0] ext_d;
  logic [OUT_W-1:0] ext_q;
  logic             valid_d;
  logic             valid_q;

  // The extension forms depend only on instr. Reset, the clock and the mode
  // inputs never affect them.
  always_comb begin
    oinstr  = {{PAD_W{instr[IN_W-1]}}, instr};
    ozext   = {{PAD_W{1'b0}}, instr};
    // The shift drops the two top sign bits and puts zeros in bits [1:0].
    obranch = {oinstr[OUT_W-3:0], 2'b00};
    olui    = {instr, {PAD_W{1'b0}}};
  end

  // Choose the form that the register captures.
  always_comb begin
    sel_ext = oinstr;
    case (ext_mode_e'(ext_mode))
      MODE_SIGN:   sel_ext = oinstr;
      MODE_ZERO:   sel_ext = ozext;
      MODE_BRANCH: sel_ext = obranch;
      MODE_LUI:    sel_ext = olui;
      default:     sel_ext = oinstr;
    endcase
  end

  // Load on ext_en, otherwise hold the current value.
  always_comb begin
    ext_d   = ext_q;
    valid_d = valid_q;
    if (ext_en) begin
      ext_d   = sel_ext;
      valid_d = 1'b1;
    end
  end

  // Registered result. An asynchronous reset clears it at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      ext_q   <= ext_d;
      valid_q <= valid_d;
    end
  end

  assign oext_q     = ext_q;
  assign oext_valid = valid_q;

endmodule

// File: tb/tb_extencion_signo.sv
// Directed bench for extencion_signo. The expected values are hand-computed
// constants.
module tb_extencion_signo;

  logic        clk;
  logic        clk_run;
  logic        rst_n;
  logic [15:0] instr;
  logic [31:0] oinstr;
  logic [31:0] ozext;
  logic [31:0] obranch;
  logic [31:0] olui;
  logic [1:0]  ext_mode;
  logic        ext_en;
  logic [31:0] oext_q;
  logic        oext_valid;

  int checks;
  int failures;

  extencion_signo #(.IN_W(16), .OUT_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .oinstr     (oinstr),
    .ozext      (ozext),
    .obranch    (obranch),
    .olui       (olui),
    .ext_mode   (ext_mode),
    .ext_en     (ext_en),
    .oext_q     (oext_q),
    .oext_valid (oext_valid)
  );

  // Clock and reset: the clock toggles only while clk_run is high.
  initial clk = 1'b0;
  always #5 if (clk_run) clk = ~clk;

  // Count one comparison and report it if it does not match.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Wait for the next rising edge, then sample away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive instr, wait, then check all four combinational forms.
  task automatic comb_vec(input logic [15:0] v, input logic [31:0] e_s,
                          input logic [31:0] e_z, input logic [31:0] e_b,
                          input logic [31:0] e_l);
    instr = v;
    #1;
    check("oinstr",  oinstr,  e_s);
    check("ozext",   ozext,   e_z);
    check("obranch", obranch, e_b);
    check("olui",    olui,    e_l);
  endtask

  // Load one value through the register and check it after the edge.
  task automatic load(input logic [1:0] m, input logic [15:0] v, input logic [31:0] e);
    ext_mode = m;
    instr    = v;
    ext_en   = 1'b1;
    tick();
    check("oext_q_load", oext_q, e);
    check("oext_valid_load", {31'd0, oext_valid}, 32'd1);
  endtask

  logic [31:0] a_s;

  initial begin
    checks   = 0;
    failures = 0;
    clk_run  = 1'b0;
    rst_n    = 1'b0;
    ext_mode = 2'bxx;
    ext_en   = 1'bx;
    instr    = 16'h0000;
    #1;
    check("reset_oext_q", oext_q, 32'h0);
    check("reset_valid", {31'd0, oext_valid}, 32'd0);

    // Combinational forms: clock idle, reset held, mode inputs undriven.
    comb_vec(16'hFFFF, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFFFFFC, 32'hFFFF0000);
    comb_vec(16'h7FFF, 32'h00007FFF, 32'h00007FFF, 32'h0001FFFC, 32'h7FFF0000);
    comb_vec(16'h8000, 32'hFFFF8000, 32'h00008000, 32'hFFFE0000, 32'h80000000);
    comb_vec(16'h0000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000);

    // Alternate instr every 100 ns with no clock running.
    for (int i = 0; i < 4; i++) begin
      instr = (i % 2 == 0) ? 16'hFFFF : 16'h7FFF;
      #100;
      check("alt_oinstr", oinstr, (i % 2 == 0) ? 32'hFFFFFFFF : 32'h00007FFF);
    end

    // Flipping only bit 15 must flip oinstr[31:15].
    instr = 16'h1234;
    #1;
    a_s = oinstr;
    instr = 16'h9234;
    #1;
    check("bit15_flip", a_s ^ oinstr, 32'hFFFF8000);

    // Registered path: release reset between edges, then load.
    ext_en   = 1'b0;
    ext_mode = 2'b00;
    clk_run  = 1'b1;
    #12;
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", oext_q, 32'h0);
    check("idle_valid", {31'd0, oext_valid}, 32'd0);

    load(2'b10, 16'h8001, 32'hFFFE0004);
    load(2'b00, 16'h1234, 32'h00001234);
    load(2'b01, 16'h8000, 32'h00008000);
    load(2'b11, 16'hABCD, 32'hABCD0000);
    load(2'b00, 16'hFFFE, 32'hFFFFFFFE);

    // With ext_en low, the register holds while instr and ext_mode change.
    ext_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      instr    = 16'h0F0F + 16'(i);
      ext_mode = 2'(i);
      tick();
      check("hold_oext_q", oext_q, 32'hFFFFFFFE);
      check("hold_valid", {31'd0, oext_valid}, 32'd1);
    end

    // Asserting reset between edges clears the register at once.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clr_q", oext_q, 32'h0);
    check("async_clr_valid", {31'd0, oext_valid}, 32'd0);
    check("oinstr_in_reset", oinstr, 32'h00000F11);

    // A load attempted while reset is held must have no effect.
    ext_en = 1'b1;
    tick();
    check("reset_blocks_load", oext_q, 32'h0);

    clk_run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
